// File: rtl/handshake_pkg.sv
// handshake_pkg: shared FSM states, ready-mode encodings and LFSR polynomials for the handshake blocks
package handshake_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {RDY_ALWAYS, RDY_HALF, RDY_QUARTER, RDY_NEVER} rdy_mode_t;
    localparam logic [31:0] DATA_POLY = 32'h8020_0003;
    localparam logic [15:0] RDY_POLY  = 16'hB400;
    // Two low LFSR bits give a ~50% (one bit) or ~25% (both bits) ready duty.
    function automatic logic rdy_pick(input rdy_mode_t m, input logic [15:0] r);
        return m == RDY_ALWAYS ? 1'b1 : m == RDY_HALF ? r[0] : m == RDY_QUARTER ? r[0] & r[1] : 1'b0;
    endfunction
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: right-shifting Galois LFSR with synchronous load to seed
//   clk, rst_n : clock, synchronous active-low reset (reloads SEED)
//   load       : reload SEED (priority over adv)
//   adv        : step one position
//   q          : current LFSR state
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = '1,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n || load) q <= SEED;
        else if (adv) q <= {1'b0, q[WIDTH-1:1]} ^ (q[0] ? POLY : '0);
    end
endmodule

// File: rtl/handshake_sink_checker.sv
// handshake_sink_checker: valid/ready sink with programmable backpressure, LFSR data check and source hold-rule check
//   clk, rst_n            : clock, synchronous active-low reset
//   start, num_words      : run request and run length (sampled when not running)
//   ready_mode            : 00 always, 01 ~50%, 10 ~25%, 11 never ready
//   s_valid, s_data       : source side of the stream
//   s_ready               : registered sink ready
//   busy, done            : FSM in RUN / DONE
//   rx_count, err_count   : accepted words, saturating data mismatches
//   data_err, first_err_idx : sticky mismatch flag and index of first mismatch
//   proto_err             : sticky source hold-rule violation
module handshake_sink_checker
    import handshake_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            CNT_W     = 16,
    parameter logic [DW-1:0] DATA_SEED = 32'h0000_0001,
    parameter logic [15:0]   RDY_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [1:0]       ready_mode,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    output logic             s_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] err_count,
    output logic             data_err,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             proto_err
);
    state_t           state, state_d;
    rdy_mode_t        mode;
    logic [CNT_W-1:0] nw;
    logic [DW-1:0]    exp_q, held;
    logic [15:0]      rdy_q;
    logic             xfer, go, last, mism, stall_q, ready_d;

    assign xfer = s_valid & s_ready;
    assign go   = start & (state != RUN);
    assign last = xfer & (rx_count + 1'b1 == nw);
    assign mism = xfer & (s_data != exp_q);
    assign busy = state == RUN;
    assign done = state == DONE;

    lfsr_galois #(.WIDTH(DW), .POLY(DATA_POLY), .SEED(DATA_SEED)) u_exp (
        .clk(clk), .rst_n(rst_n), .load(go), .adv(xfer), .q(exp_q)
    );

    lfsr_galois #(.WIDTH(16), .POLY(RDY_POLY), .SEED(RDY_SEED)) u_rdy (
        .clk(clk), .rst_n(rst_n), .load(go), .adv(state == RUN), .q(rdy_q)
    );

    // On start the ready LFSR is being reloaded, so the first ready value comes from the seed.
    always_comb begin
        state_d = go ? (num_words == '0 ? DONE : RUN) : (state == RUN && last) ? DONE : state;
        ready_d = go ? (num_words != '0 && rdy_pick(rdy_mode_t'(ready_mode), RDY_SEED))
                     : (state == RUN && !last && rdy_pick(mode, rdy_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode          <= RDY_ALWAYS;
            nw            <= '0;
            s_ready       <= 1'b0;
            rx_count      <= '0;
            err_count     <= '0;
            data_err      <= 1'b0;
            first_err_idx <= '0;
            proto_err     <= 1'b0;
            stall_q       <= 1'b0;
            held          <= '0;
        end else begin
            state   <= state_d;
            s_ready <= ready_d;
            stall_q <= (state == RUN) & s_valid & ~s_ready;
            held    <= s_data;
            if (go) begin
                nw            <= num_words;
                mode          <= rdy_mode_t'(ready_mode);
                rx_count      <= '0;
                err_count     <= '0;
                data_err      <= 1'b0;
                first_err_idx <= '0;
                proto_err     <= 1'b0;
            end else begin
                if (xfer) rx_count <= rx_count + 1'b1;
                if (mism) begin
                    err_count <= err_count + {{(CNT_W-1){1'b0}}, ~&err_count};
                    data_err  <= 1'b1;
                    if (!data_err) first_err_idx <= rx_count;
                end
                if (state == RUN && stall_q && (!s_valid || s_data != held)) proto_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_handshake_sink_checker.sv
// tb_handshake_sink_checker: randomized source against a sequence model of the expected LFSR stream
module tb_handshake_sink_checker;
    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, s_ready, busy, done, data_err, proto_err;
    logic [15:0] num_words, rx_count, err_count, first_err_idx;
    logic [1:0]  ready_mode;
    logic [31:0] s_data;
    int          checks = 0;
    int          errors = 0;
    int          lat;

    handshake_sink_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .ready_mode(ready_mode),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy), .done(done),
        .rx_count(rx_count), .err_count(err_count), .data_err(data_err),
        .first_err_idx(first_err_idx), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // Source obeying the hold rule; sends the expected sequence, optionally corrupting one word.
    task automatic do_run(input int n, input int mode, input bit rnd_valid, input int corrupt,
                          input int abort_at, output int cyc);
        int          idx;
        logic [31:0] word;
        bit          pend, v, acc;
        @(negedge clk);
        num_words = 16'(n); ready_mode = 2'(mode); start = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 1; idx = 0; word = 32'h1; pend = 1'b0;
        while (!done && cyc < 3000 && idx != abort_at) begin
            v = idx < n && (pend || !rnd_valid || $urandom_range(0, 1) == 1);
            s_valid = v;
            s_data = word ^ ((idx == corrupt) ? 32'h1 : 32'h0);
            acc = v && s_ready;
            pend = v && !acc;
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                word = lfsr_next(word);
            end
        end
        s_valid = 1'b0;
        if (abort_at < 0) check("run_done", done, 1);
    endtask

    task automatic pulse_reset();
        s_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rx"}, rx_count, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_data_err"}, data_err, 0);
        check({tag, "_fei"}, first_err_idx, 0);
        check({tag, "_proto"}, proto_err, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_words = '0; ready_mode = '0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        do_run(30, 0, 0, -1, -1, lat);
        check("full_latency", lat, 31);
        check("full_rx", rx_count, 30);
        check("full_err", err_count, 0);
        check("full_proto", proto_err, 0);
        check("full_busy", busy, 0);

        do_run(30, 1, 1, -1, -1, lat);
        check("half_rx", rx_count, 30);
        check("half_data_err", data_err, 0);
        check("half_proto", proto_err, 0);
        repeat (3) begin
            @(negedge clk);
            check("half_done_ready", s_ready, 0);
            check("half_done_hold", done, 1);
        end

        do_run(30, 0, 0, 5, -1, lat);
        check("bad5_data_err", data_err, 1);
        check("bad5_err", err_count, 1);
        check("bad5_fei", first_err_idx, 5);
        check("bad5_rx", rx_count, 30);

        for (int i = 0; i < 6; i++) begin
            int n, m, c;
            n = $urandom_range(1, 40);
            m = $urandom_range(0, 2);
            c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            do_run(n, m, 1, c, -1, lat);
            check("rnd_rx", rx_count, n);
            check("rnd_err", err_count, (c >= 0) ? 1 : 0);
            check("rnd_data_err", data_err, (c >= 0) ? 1 : 0);
            check("rnd_fei", first_err_idx, (c >= 0) ? c : 0);
            check("rnd_proto", proto_err, 0);
        end

        @(negedge clk);
        num_words = 16'd5; ready_mode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("never_busy", busy, 1);
        s_valid = 1'b1; s_data = 32'hA;
        repeat (2) @(negedge clk);
        check("never_ready", s_ready, 0);
        check("hold_ok_proto", proto_err, 0);
        s_data = 32'hB;
        @(negedge clk);
        check("data_change_proto", proto_err, 1);
        check("never_still_busy", busy, 1);
        pulse_reset();
        check("reset_clears_proto", proto_err, 0);

        @(negedge clk);
        num_words = 16'd5; ready_mode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; s_data = 32'hA;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        check("valid_drop_proto", proto_err, 1);
        pulse_reset();

        do_run(0, 0, 0, -1, -1, lat);
        check("zero_latency", lat, 1);
        check("zero_rx", rx_count, 0);
        check("zero_ready", s_ready, 0);
        @(negedge clk);
        check("zero_ready_hold", s_ready, 0);

        do_run(30, 0, 0, -1, 10, lat);
        check("abort_rx", rx_count, 10);
        pulse_reset();
        check_idle("midrun_reset");
        do_run(5, 0, 0, -1, -1, lat);
        check("restart_rx", rx_count, 5);
        check("restart_err", err_count, 0);
        check("restart_data_err", data_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
